// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SYNC, LEN, payload, CHK (XOR of LEN and payload).
// Verified packets are buffered and replayed on a valid/ready byte stream. Bad traffic raises error pulses.
module uart_rx_pkt_ctrl #(
  parameter int         MAX_LEN     = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [7:0]                   pkt_data,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic                         pkt_last,
  output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
  output logic                         busy,
  output logic                         err_chk,
  output logic                         err_len,
  output logic                         err_timeout,
  output logic                         err_overrun
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LW-1:0] ONE_L     = LW'(1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t        state_r, state_next_s;
  logic [LW-1:0] len_r, len_next_s;
  logic [7:0]    chk_r, chk_next_s;
  logic [LW-1:0] wr_idx_r, wr_idx_next_s;
  logic [LW-1:0] rd_idx_r, rd_idx_next_s;
  logic [LW-1:0] rd_idx_inc_s;
  logic [TW-1:0] tcnt_r, tcnt_next_s;
  logic [7:0]    pkt_data_r, pkt_data_next_s;
  logic          pkt_valid_r, pkt_valid_next_s;
  logic          pkt_last_r, pkt_last_next_s;
  logic [LW-1:0] pkt_len_r, pkt_len_next_s;
  logic          busy_r;
  logic          err_chk_r, err_chk_next_s;
  logic          err_len_r, err_len_next_s;
  logic          err_timeout_r, err_timeout_next_s;
  logic          err_overrun_r, err_overrun_next_s;
  logic          buf_we_s;
  logic          timeout_hit_s;
  logic [7:0]    buf_mem [0:(1<<IW)-1];

  assign rd_idx_inc_s  = rd_idx_r + ONE_L;
  assign timeout_hit_s = (tcnt_r == TMAX);

  // Next-state and next-value logic for the framer and the output stream
  always_comb begin
    state_next_s       = state_r;
    len_next_s         = len_r;
    chk_next_s         = chk_r;
    wr_idx_next_s      = wr_idx_r;
    rd_idx_next_s      = rd_idx_r;
    tcnt_next_s        = tcnt_r;
    pkt_data_next_s    = pkt_data_r;
    pkt_valid_next_s   = pkt_valid_r;
    pkt_last_next_s    = pkt_last_r;
    pkt_len_next_s     = pkt_len_r;
    err_chk_next_s     = 1'b0;
    err_len_next_s     = 1'b0;
    err_timeout_next_s = 1'b0;
    err_overrun_next_s = 1'b0;
    buf_we_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        tcnt_next_s = {TW{1'b0}};
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_next_s = ST_LEN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LEN: begin
        if (rx_valid) begin
          tcnt_next_s = {TW{1'b0}};
          if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
            err_len_next_s = 1'b1;
            state_next_s   = ST_IDLE;
          end else begin
            len_next_s    = rx_data[LW-1:0];
            chk_next_s    = rx_data;
            wr_idx_next_s = {LW{1'b0}};
            state_next_s  = ST_PAYLOAD;
          end
        end else if (timeout_hit_s) begin
          err_timeout_next_s = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tcnt_next_s = tcnt_r + TW'(1);
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid) begin
          tcnt_next_s   = {TW{1'b0}};
          buf_we_s      = 1'b1;
          chk_next_s    = chk_fold(chk_r, rx_data);
          wr_idx_next_s = wr_idx_r + ONE_L;
          if (wr_idx_r == (len_r - ONE_L)) begin
            state_next_s = ST_CHK;
          end else begin
            state_next_s = ST_PAYLOAD;
          end
        end else if (timeout_hit_s) begin
          err_timeout_next_s = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tcnt_next_s = tcnt_r + TW'(1);
        end
      end
      ST_CHK: begin
        if (rx_valid) begin
          tcnt_next_s = {TW{1'b0}};
          if (rx_data == chk_r) begin
            // First beat is presented straight from the buffer so pkt_valid rises next cycle
            state_next_s     = ST_OUT;
            rd_idx_next_s    = {LW{1'b0}};
            pkt_len_next_s   = len_r;
            pkt_valid_next_s = 1'b1;
            pkt_data_next_s  = buf_mem[{IW{1'b0}}];
            pkt_last_next_s  = (len_r == ONE_L);
          end else begin
            err_chk_next_s = 1'b1;
            state_next_s   = ST_IDLE;
          end
        end else if (timeout_hit_s) begin
          err_timeout_next_s = 1'b1;
          state_next_s       = ST_IDLE;
        end else begin
          tcnt_next_s = tcnt_r + TW'(1);
        end
      end
      ST_OUT: begin
        tcnt_next_s = {TW{1'b0}};
        if (rx_valid) begin
          err_overrun_next_s = 1'b1;
        end else begin
          err_overrun_next_s = 1'b0;
        end
        if (pkt_valid_r && pkt_ready) begin
          if (pkt_last_r) begin
            pkt_valid_next_s = 1'b0;
            pkt_last_next_s  = 1'b0;
            state_next_s     = ST_IDLE;
          end else begin
            rd_idx_next_s   = rd_idx_inc_s;
            pkt_data_next_s = buf_mem[rd_idx_inc_s[IW-1:0]];
            pkt_last_next_s = (rd_idx_inc_s == (len_r - ONE_L));
          end
        end else begin
          state_next_s = ST_OUT;
        end
      end
      default: begin
        state_next_s     = ST_IDLE;
        pkt_valid_next_s = 1'b0;
        pkt_last_next_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      len_r         <= {LW{1'b0}};
      chk_r         <= 8'h00;
      wr_idx_r      <= {LW{1'b0}};
      rd_idx_r      <= {LW{1'b0}};
      tcnt_r        <= {TW{1'b0}};
      pkt_data_r    <= 8'h00;
      pkt_valid_r   <= 1'b0;
      pkt_last_r    <= 1'b0;
      pkt_len_r     <= {LW{1'b0}};
      busy_r        <= 1'b0;
      err_chk_r     <= 1'b0;
      err_len_r     <= 1'b0;
      err_timeout_r <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      len_r         <= len_next_s;
      chk_r         <= chk_next_s;
      wr_idx_r      <= wr_idx_next_s;
      rd_idx_r      <= rd_idx_next_s;
      tcnt_r        <= tcnt_next_s;
      pkt_data_r    <= pkt_data_next_s;
      pkt_valid_r   <= pkt_valid_next_s;
      pkt_last_r    <= pkt_last_next_s;
      pkt_len_r     <= pkt_len_next_s;
      busy_r        <= (state_next_s != ST_IDLE);
      err_chk_r     <= err_chk_next_s;
      err_len_r     <= err_len_next_s;
      err_timeout_r <= err_timeout_next_s;
      err_overrun_r <= err_overrun_next_s;
    end
  end

  // Payload buffer; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      buf_mem[wr_idx_r[IW-1:0]] <= rx_data;
    end
  end

  assign pkt_data    = pkt_data_r;
  assign pkt_valid   = pkt_valid_r;
  assign pkt_last    = pkt_last_r;
  assign pkt_len     = pkt_len_r;
  assign busy        = busy_r;
  assign err_chk     = err_chk_r;
  assign err_len     = err_len_r;
  assign err_timeout = err_timeout_r;
  assign err_overrun = err_overrun_r;

endmodule
